// File: rtl/dc_ipu_array_multiplier_pkg.sv
// rtl/dc_ipu_array_multiplier_pkg.sv - shared helpers for the pipelined array multiplier
package dc_ipu_array_multiplier_pkg;

  // Number of pipeline stages; each stage folds in rows_per_stage partial-product rows.
  // The per-stage record (valid, acc, a, b, user) depends on WIDTH/USER_W, so it is
  // declared as a parameterized packed struct inside the top module.
  function automatic int nstages(input int width, input int rows_per_stage);
    if (rows_per_stage <= 0) begin
      return 1;
    end
    return width / rows_per_stage;
  endfunction

endpackage

// File: rtl/dc_ipu_array_multiplier_stage_comb.sv
// rtl/dc_ipu_array_multiplier_stage_comb.sv - combinational partial-product row adder for one stage
module dc_ipu_array_multiplier_stage_comb #(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_STAGE = 2,
  parameter int ROW_BASE       = 0
) (
  input  logic [2*WIDTH-1:0]      acc_in,
  input  logic [2*WIDTH-1:0]      a,
  input  logic [ROWS_PER_STAGE-1:0] b,
  output logic [2*WIDTH-1:0]      acc_out
);

  // Add row (ROW_BASE + r) = b[r] ? a << (ROW_BASE + r) : 0; full 2*WIDTH width cannot overflow
  always_comb begin
    acc_out = acc_in;
    for (int r = 0; r < ROWS_PER_STAGE; r++) begin
      if (b[r]) begin
        acc_out = acc_out + (a << (ROW_BASE + r));
      end
    end
  end

endmodule

// File: rtl/dc_ipu_array_multiplier_pipe.sv
// rtl/dc_ipu_array_multiplier_pipe.sv - pipelined unsigned array multiplier with valid/ready and user sideband
module dc_ipu_array_multiplier_pipe
  import dc_ipu_array_multiplier_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_STAGE = 2,
  parameter int USER_W         = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [USER_W-1:0]    in_user,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [USER_W-1:0]    out_user
);

  localparam int NSTAGES = nstages(WIDTH, ROWS_PER_STAGE);

  if ((WIDTH < 2) || (ROWS_PER_STAGE < 1) || ((WIDTH % ROWS_PER_STAGE) != 0)) begin : g_bad_cfg
    $error("dc_ipu_array_multiplier_pipe: WIDTH must be >= 2 and a multiple of ROWS_PER_STAGE");
  end

  typedef struct packed {
    logic                valid;
    logic [2*WIDTH-1:0]  acc;
    logic [2*WIDTH-1:0]  a;
    logic [WIDTH-1:0]    b;
    logic [USER_W-1:0]   user;
  } stage_t;

  logic adv;

  // The whole pipe moves as one: it advances whenever the output slot is empty or being taken.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    stage_t             src;
    logic [2*WIDTH-1:0] acc_nxt;

    if (k == 0) begin : g_first
      // Stage 0 source is the input port with an empty accumulator
      always_comb begin
        src       = '0;
        src.valid = in_valid;
        src.acc   = '0;
        src.a     = {{WIDTH{1'b0}}, in_a};
        src.b     = in_b;
        src.user  = in_user;
      end
    end else begin : g_next
      assign src = g_stage[k-1].g_mid.q;
    end

    dc_ipu_array_multiplier_stage_comb #(
      .WIDTH          (WIDTH),
      .ROWS_PER_STAGE (ROWS_PER_STAGE),
      .ROW_BASE       (k * ROWS_PER_STAGE)
    ) u_rows (
      .acc_in  (src.acc),
      .a       (src.a),
      .b       (src.b[k*ROWS_PER_STAGE +: ROWS_PER_STAGE]),
      .acc_out (acc_nxt)
    );

    if (k < NSTAGES - 1) begin : g_mid
      stage_t q;

      // Intermediate stage register: bubbles advance like valid slots, everything freezes on stall
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (adv) begin
          q.valid <= src.valid;
          q.acc   <= acc_nxt;
          q.a     <= src.a;
          q.b     <= src.b;
          q.user  <= src.user;
        end
      end
    end else begin : g_last
      // Final stage register drives the outputs directly; the operands are no longer needed
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid   <= 1'b0;
          out_product <= '0;
          out_user    <= '0;
        end else if (adv) begin
          out_valid   <= src.valid;
          out_product <= acc_nxt;
          out_user    <= src.user;
        end
      end
    end
  end

endmodule

// File: doc/dc_ipu_array_multiplier_pipe.md
Name: dc_ipu_array_multiplier_pipe

Overview:
- Pipelined unsigned array multiplier for the IPU scaler datapath; the forward counterpart of the array divider.
- Computes product = a * b, producing the full 2*WIDTH-bit product.
- Adds ROWS_PER_STAGE shifted partial-product rows per pipeline stage.
- Valid/ready streaming interface with full-pipeline backpressure; carries a user sideband (e.g. pixel/coefficient tag) aligned with the data.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2.
- ROWS_PER_STAGE, 2, partial-product rows per pipeline stage; WIDTH % ROWS_PER_STAGE == 0 (elaboration-time $error otherwise).
- USER_W, 1, sideband width passed through unchanged.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- in_a  input  WIDTH  multiplicand, unsigned.
- in_b  input  WIDTH  multiplier, unsigned.
- in_user  input  USER_W  sideband, travels with operands.
- out_valid  output  1  product valid.
- out_ready  input  1  downstream accepts product.
- out_product  output  2*WIDTH  a*b, exact, no truncation.
- out_user  output  USER_W  sideband of the same transaction.

Behaviour:
- NSTAGES = WIDTH / ROWS_PER_STAGE. Latency = NSTAGES cycles from accepted input to out_valid with out_ready held high; throughput 1/cycle.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv, purely combinational; no dependency on in_valid (no comb loop).
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- On adv, each stage register loads from the previous stage; stage 0 loads the input, with valid = in_valid. When adv = 0 every stage holds: data, valid and user are all frozen.
- Bubbles are not collapsed: an invalid slot advances like a valid one.
- Stage k register contents:
  - valid.
  - accumulator, 2*WIDTH bits.
  - multiplicand a, zero-extended to 2*WIDTH.
  - remaining multiplier bits b.
  - user.
- Stage k adds rows i = k*ROWS_PER_STAGE .. (k+1)*ROWS_PER_STAGE-1, each row being (b[i] ? a << i : 0), to its accumulator.
- Accumulator addition is 2*WIDTH wide, unsigned, with no overflow possible. The maximum is (2^W-1)^2 < 2^(2W).
- out_product, out_user and out_valid come directly from the last stage register (registered outputs).
- Reset (asynchronous assert, synchronous deassert handled upstream): all valid bits 0 and all data/user registers 0. Hence out_valid = 0, out_product = 0, out_user = 0, in_ready = 1.
- Reset mid-operation: all in-flight transactions are discarded; no output is produced for them after reset release.
- Output stability: while out_valid && !out_ready, out_product and out_user must not change.
- Data-register contents of invalid slots are don't-care internally but must be deterministic. No X is allowed on outputs after reset.
- Corner values: a = 0 or b = 0 gives 0. WIDTH-bit all-ones gives (2^W-1)^2.

Decomposition:
- Package dc_ipu_array_multiplier_pkg holds:
  - function clog2-free helper nstages(WIDTH, ROWS_PER_STAGE).
  - typedef template note for the stage record (valid, acc, a, b, user); this is a parameterized struct inside the module, since a package cannot be parameterized.
- Sub-module dc_ipu_array_multiplier_stage_comb (parameters WIDTH, ROWS_PER_STAGE, ROW_BASE):
  - combinational row adder.
  - inputs acc_in, a, b; output acc_out.
  - instantiated NSTAGES times in a generate loop.
  - the top owns all registers and the handshake.

Test Plan (WIDTH=8, ROWS_PER_STAGE=2, latency 4):
- Single op, a=255 b=255, out_ready=1 -> out_valid exactly 4 cycles after acceptance, out_product=16'hFE01, for one cycle only.
- Zero/identity: (0,173) -> 0; (1,173) -> 173; (128,2) -> 256; (16,16) -> 256; user tags 0,1,0,1 returned in order.
- Back-to-back stream of 20 random pairs, in_valid=1 continuously, out_ready=1 -> 20 outputs on consecutive cycles matching the reference model, in order, with matching user.
- Backpressure: stream running, out_ready=0 for 5 cycles -> in_ready=0 those cycles, out_product/out_user stable, no loss or duplication; after release the sequence continues intact. Also random out_ready at 50% over 1000 transactions, checked against a scoreboard.
- Bubbles: in_valid pattern 1,0,0,1 -> outputs keep the same gaps (cycles 4 and 7 after the first acceptance).
- Reset mid-flight: 3 transactions in pipe, assert rst_n=0 asynchronously between edges -> out_valid=0 and out_product=0 immediately. After release, no stale output appears, in_ready=1, and a new op (12*13) gives 156 after 4 cycles.
